mat_mult_seq: RTL

Sequencer for the coprocessor's signed int8 matrix-multiply path. It latches two square matrices of up to 5x5 elements and steps one multiply-accumulate per clock over every (row, column, k) index. It writes each finished dot product into a packed result matrix and raises a sticky overflow flag. It sits between the command/register interface and the multiply datapath, and provides start/busy/done sequencing in place of one-shot combinational operation.

---
 rtl/mat_mult_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mat_mult_seq.sv
// mat_mult_seq: sequential signed int8 matrix multiplier for up to 5x5 operands.
// One multiply-accumulate per clock over (i, j, k); start/busy/done handshake,
// packed 5x5 result with (0,0) in the MSBs, sticky int8 overflow flag.
module mat_mult_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   size,
  input  logic [199:0] mat_a,
  input  logic [199:0] mat_b,
  output logic [199:0] result,
  output logic         busy,
  output logic         done,
  output logic         ovf
);

  localparam int unsigned DIM = 5;
  localparam int unsigned EW  = 8;
  localparam int unsigned MW  = DIM * DIM * EW;
  localparam int unsigned IW  = 3;
  localparam int unsigned PW  = 2 * EW;
  localparam int unsigned AW  = 18;
  localparam int unsigned LW  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [MW-1:0]        a_q, b_q;
  logic [IW-1:0]        n_q, i_q, j_q, k_q;
  logic signed [AW-1:0] acc_q;

  logic [IW-1:0]        n_c, nm1;
  logic [LW-1:0]        a_lsb, b_lsb, r_lsb;
  logic signed [EW-1:0] a_el, b_el;
  logic signed [PW-1:0] p;
  logic signed [AW-1:0] p_ext, s;
  logic                 ovr, k_last, last;

  // Operand indexing, product, running sum and end-of-operation detection
  always_comb begin
    n_c    = ((size == 3'd0) || (size > 3'd5)) ? 3'd5 : size;
    nm1    = n_q - 3'd1;
    a_lsb  = LW'(MW - EW - EW * (DIM * i_q + k_q));
    b_lsb  = LW'(MW - EW - EW * (DIM * k_q + j_q));
    r_lsb  = LW'(MW - EW - EW * (DIM * i_q + j_q));
    a_el   = a_q[a_lsb +: EW];
    b_el   = b_q[b_lsb +: EW];
    p      = PW'(a_el) * PW'(b_el);
    p_ext  = AW'(p);
    s      = acc_q + p_ext;
    ovr    = (s > 18'sd127) || (s < -18'sd128);
    k_last = (k_q == nm1);
    last   = k_last && (j_q == nm1) && (i_q == nm1);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_MAC;
      ST_MAC:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered handshake outputs, aligned with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == ST_MAC);
      done <= (state_nxt == ST_DONE);
    end
  end

  // Operand latch, index walk, accumulation and result write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= 3'd5;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q    <= mat_a;
            b_q    <= mat_b;
            n_q    <= n_c;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            acc_q  <= '0;
            result <= '0;
            ovf    <= 1'b0;
          end
        end
        ST_MAC: begin
          if (!k_last) begin
            acc_q <= s;
            k_q   <= k_q + 3'd1;
          end else begin
            result[r_lsb +: EW] <= s[EW-1:0];
            ovf   <= ovf | ovr;
            acc_q <= '0;
            k_q   <= '0;
            if (j_q == nm1) begin
              j_q <= '0;
              i_q <= i_q + 3'd1;
            end else begin
              j_q <= j_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
